// File: rtl/lfsr_gen.sv
// lfsr_gen: parametrised Fibonacci LFSR pseudo-random source.
//
// Each "advance" applies STEPS chained single shifts in one cycle:
//   fb = XOR of tap bits, q_next = {q[W-2:0], fb}.
// The all-zero state is unreachable: loading a zero seed substitutes SEED
// and pulses err. A counted burst mode advances once per cycle for cnt
// cycles with a busy/done handshake.
//
// Handshake: start is a single-cycle request sampled on the rising edge
// together with cnt. It is accepted only while busy is low. busy is high for
// exactly cnt cycles after the accepting edge. done is a one-cycle pulse in
// the cycle after busy falls. load always wins and aborts a burst without
// done.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous, active-low reset
//   enb        free-run enable (one advance per cycle while idle)
//   load       load seed_in on the next edge (SEED if seed_in is zero)
//   seed_in    runtime seed, W bits
//   start      burst request, sampled with cnt
//   cnt        burst length in advances, CW bits
//   q          current LFSR state
//   busy       burst in progress
//   done       one-cycle pulse at burst completion
//   err        one-cycle pulse when a zero seed was rejected
//   fsm_state  debug view of the burst FSM (0 = IDLE, 1 = RUN)
module lfsr_gen #(
  parameter int          W     = 32,
  parameter logic [W-1:0] SEED = {{(W-1){1'b0}}, 1'b1},
  parameter int          STEPS = 1,
  parameter int          CW    = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          enb,
  input  logic          load,
  input  logic [W-1:0]  seed_in,
  input  logic          start,
  input  logic [CW-1:0] cnt,
  output logic [W-1:0]  q,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic          fsm_state
);

  // Parameter legality is checked at elaboration.
  if (!(W == 8 || W == 16 || W == 24 || W == 32 || W == 64)) begin : g_bad_w
    $error("lfsr_gen: W must be 8, 16, 24, 32 or 64");
  end
  if (SEED == '0) begin : g_bad_seed
    $error("lfsr_gen: SEED must be nonzero");
  end
  if (STEPS < 1 || STEPS > W) begin : g_bad_steps
    $error("lfsr_gen: STEPS must be in 1..W");
  end

  // Tap masks: bit n (1-indexed) of the tap list is mask bit n-1.
  function automatic logic [63:0] tap_mask_f(input int w);
    case (w)
      8:       return 64'h0000_0000_0000_00B8; // 8,6,5,4
      16:      return 64'h0000_0000_0000_D008; // 16,15,13,4
      24:      return 64'h0000_0000_00E1_0000; // 24,23,22,17
      32:      return 64'h0000_0000_8020_0003; // 32,22,2,1
      64:      return 64'hD800_0000_0000_0000; // 64,63,61,60
      default: return 64'h0;
    endcase
  endfunction

  localparam logic [63:0]  TAP_ALL  = tap_mask_f(W);
  localparam logic [W-1:0] TAP_MASK = TAP_ALL[W-1:0];

  // STEPS single shifts unrolled into one combinational advance.
  function automatic logic [W-1:0] advance(input logic [W-1:0] s);
    logic [W-1:0] r;
    r = s;
    for (int i = 0; i < STEPS; i++) begin
      r = {r[W-2:0], ^(r & TAP_MASK)};
    end
    return r;
  endfunction

  typedef enum logic { IDLE = 1'b0, RUN = 1'b1 } state_t;

  state_t        state;
  logic [CW-1:0] remaining;
  logic [W-1:0]  q_adv;

  always_comb begin
    q_adv = advance(q);
  end

  assign fsm_state = state;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      q         <= SEED;
      remaining <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      // Pulses last exactly one cycle unless re-asserted below.
      done <= 1'b0;
      err  <= 1'b0;
      if (load) begin
        // Load aborts any burst; no done is produced for an aborted burst.
        if (seed_in == '0) begin
          q   <= SEED;
          err <= 1'b1;
        end else begin
          q <= seed_in;
        end
        state     <= IDLE;
        busy      <= 1'b0;
        remaining <= '0;
      end else if (state == RUN) begin
        // One advance per busy cycle; enb and start are ignored here.
        q         <= q_adv;
        remaining <= remaining - CW'(1);
        if (remaining == CW'(1)) begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end
      end else if (start) begin
        if (cnt == '0) begin
          // Empty burst: no advance, completion reported immediately.
          done <= 1'b1;
        end else begin
          state     <= RUN;
          busy      <= 1'b1;
          remaining <= cnt;
        end
      end else if (enb) begin
        q <= q_adv;
      end
    end
  end

endmodule

// File: tb/tb_lfsr_gen.sv
// Testbench for lfsr_gen: three instances (W=8/STEPS=1, W=8/STEPS=4,
// W=32/STEPS=1) share one control stream. A driver applies inputs on the
// falling edge and pushes each instance's expected post-edge outputs into
// its queue; a monitor pops and compares after every rising edge.
module tb_lfsr_gen;

  localparam int CW = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic          enb = 0, load = 0, start = 0;
  logic [CW-1:0] cnt = '0;
  logic [63:0]   seed = '0;

  logic [7:0]  qa, qb;
  logic [31:0] qc;
  logic busya, donea, erra, sta;
  logic busyb, doneb, errb, stb;
  logic busyc, donec, errc, stc;

  lfsr_gen #(.W(8), .SEED(8'h01), .STEPS(1), .CW(CW)) u_a (
    .clk(clk), .rst(rst), .enb(enb), .load(load), .seed_in(seed[7:0]),
    .start(start), .cnt(cnt), .q(qa), .busy(busya), .done(donea),
    .err(erra), .fsm_state(sta));

  lfsr_gen #(.W(8), .SEED(8'h01), .STEPS(4), .CW(CW)) u_b (
    .clk(clk), .rst(rst), .enb(enb), .load(load), .seed_in(seed[7:0]),
    .start(start), .cnt(cnt), .q(qb), .busy(busyb), .done(doneb),
    .err(errb), .fsm_state(stb));

  lfsr_gen #(.W(32), .SEED(32'h1), .STEPS(1), .CW(CW)) u_c (
    .clk(clk), .rst(rst), .enb(enb), .load(load), .seed_in(seed[31:0]),
    .start(start), .cnt(cnt), .q(qc), .busy(busyc), .done(donec),
    .err(errc), .fsm_state(stc));

  // ---------------- reference model ----------------
  // Abstract state: value, number of burst advances still owed, pulses.
  typedef struct packed {
    logic [63:0] q;
    logic [31:0] left;
    logic        done;
    logic        err;
  } m_t;

  m_t ma, mb, mc;

  function automatic logic [63:0] width_mask(input int w);
    if (w == 64) return '1;
    return (64'd1 << w) - 64'd1;
  endfunction

  function automatic int tap_pos(input int w, input int i);
    int t8[4]  = '{8, 6, 5, 4};
    int t32[4] = '{32, 22, 2, 1};
    if (w == 8) return t8[i];
    return t32[i];
  endfunction

  // Shift count n, one bit at a time, from the tap position list.
  function automatic logic [63:0] ref_shift(input logic [63:0] v, input int w, input int n);
    logic [63:0] r;
    logic        fb;
    r = v;
    for (int k = 0; k < n; k++) begin
      fb = 1'b0;
      for (int i = 0; i < 4; i++) fb = fb ^ r[tap_pos(w, i) - 1];
      r = ((r << 1) | {63'b0, fb}) & width_mask(w);
    end
    return r;
  endfunction

  function automatic m_t model_next(input m_t m, input int w, input int steps,
                                    input logic e, input logic l, input logic s,
                                    input logic [CW-1:0] c, input logic [63:0] sd);
    m_t n;
    logic [63:0] sdm;
    n = m;
    n.done = 1'b0;
    n.err  = 1'b0;
    sdm = sd & width_mask(w);
    if (l) begin
      n.left = 0;
      if (sdm == 64'd0) begin
        n.q = 64'd1;
        n.err = 1'b1;
      end else begin
        n.q = sdm;
      end
    end else if (m.left != 0) begin
      n.q = ref_shift(m.q, w, steps);
      n.left = m.left - 1;
      if (n.left == 0) n.done = 1'b1;
    end else if (s) begin
      if (c == '0) n.done = 1'b1;
      else n.left = {16'b0, c};
    end else if (e) begin
      n.q = ref_shift(m.q, w, steps);
    end
    return n;
  endfunction

  function automatic m_t model_reset();
    m_t m;
    m.q = 64'd1;
    m.left = 0;
    m.done = 1'b0;
    m.err = 1'b0;
    return m;
  endfunction

  function automatic logic [66:0] pack_exp(input m_t m);
    return {m.q, (m.left != 0), m.done, m.err};
  endfunction

  // ---------------- scoreboard ----------------
  logic [66:0] exp_a[$];
  logic [66:0] exp_b[$];
  logic [66:0] exp_c[$];
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [66:0] act, input logic [66:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got q=%h busy=%b done=%b err=%b, expected q=%h busy=%b done=%b err=%b",
               name, act[66:3], act[2], act[1], act[0], exp[66:3], exp[2], exp[1], exp[0]);
    end
  endtask

  task automatic check_val(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitor: one comparison per instance after each edge with pending data.
  always @(posedge clk) begin
    #1;
    if (rst) begin
      if (exp_a.size() > 0) check("dut_w8_s1", {56'b0, qa, busya, donea, erra}, exp_a.pop_front());
      if (exp_b.size() > 0) check("dut_w8_s4", {56'b0, qb, busyb, doneb, errb}, exp_b.pop_front());
      if (exp_c.size() > 0) check("dut_w32_s1", {32'b0, qc, busyc, donec, errc}, exp_c.pop_front());
    end
  end

  // ---------------- driver ----------------
  task automatic drive(input logic e, input logic l, input logic s,
                       input logic [CW-1:0] c, input logic [63:0] sd);
    @(negedge clk);
    enb = e; load = l; start = s; cnt = c; seed = sd;
    ma = model_next(ma, 8, 1, e, l, s, c, sd);
    mb = model_next(mb, 8, 4, e, l, s, c, sd);
    mc = model_next(mc, 32, 1, e, l, s, c, sd);
    exp_a.push_back(pack_exp(ma));
    exp_b.push_back(pack_exp(mb));
    exp_c.push_back(pack_exp(mc));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, '0, '0);
  endtask

  // Sample point just after the edge that the last drive() set up.
  task automatic after_edge();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    enb = 0; load = 0; start = 0; cnt = '0; seed = '0;
    exp_a.delete(); exp_b.delete(); exp_c.delete();
    ma = model_reset(); mb = model_reset(); mc = model_reset();
    @(negedge clk);
    rst = 1'b1;
  endtask

  logic [7:0] walk[4] = '{8'h02, 8'h04, 8'h08, 8'h11};

  initial begin
    ma = model_reset(); mb = model_reset(); mc = model_reset();
    #12;
    // Reset values.
    check("reset_a", {56'b0, qa, busya, donea, erra}, {64'h1, 3'b000});
    check("reset_c", {32'b0, qc, busyc, donec, errc}, {64'h1, 3'b000});
    @(negedge clk);
    rst = 1'b1;

    // Free-run walk from SEED=01.
    for (int i = 0; i < 4; i++) begin
      drive(1, 0, 0, '0, '0);
      after_edge();
      check_val("walk_a", {56'b0, qa}, {56'b0, walk[i]});
      if (i == 0) check_val("steps4_first", {56'b0, qb}, 64'h11);
    end
    // Complete the period: 255 total advances returns to 01.
    for (int i = 4; i < 255; i++) drive(1, 0, 0, '0, '0);
    after_edge();
    check_val("period_a", {56'b0, qa}, 64'h01);
    idle(10);
    after_edge();

    // Burst of 4 from 01 with enb low.
    do_reset();
    drive(0, 0, 1, 16'd4, '0);
    after_edge();
    check_val("burst_busy", {63'b0, busya}, 64'h1);
    idle(4);
    after_edge();
    check_val("burst_done_q", {55'b0, qa, donea}, {55'b0, 8'h11, 1'b1});
    drive(0, 0, 1, 16'd0, '0);
    after_edge();
    check_val("cnt0_done_q", {55'b0, qa, donea}, {55'b0, 8'h11, 1'b1});
    idle(2);

    // Zero-seed rejection and a normal load.
    drive(0, 1, 0, '0, 64'h0);
    after_edge();
    check_val("load_zero", {55'b0, qa, erra}, {55'b0, 8'h01, 1'b1});
    drive(0, 1, 0, '0, 64'hA5A5_A5A5);
    after_edge();
    check_val("load_a5", {55'b0, qa, erra}, {55'b0, 8'hA5, 1'b0});
    idle(2);

    // Load aborts a burst of 10 in its third busy cycle.
    drive(1, 0, 1, 16'd10, '0);
    idle(2);
    drive(0, 1, 0, '0, 64'h3C);
    after_edge();
    check_val("abort_load", {55'b0, qa, busya}, {55'b0, 8'h3C, 1'b0});
    idle(12);
    after_edge();

    // Asynchronous reset in the middle of a burst.
    drive(0, 0, 1, 16'd10, '0);
    idle(3);
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    check_val("async_rst_a", {55'b0, qa, busya}, {55'b0, 8'h01, 1'b0});
    check_val("async_rst_c", {31'b0, qc, busyc}, {31'b0, 32'h1, 1'b0});
    exp_a.delete(); exp_b.delete(); exp_c.delete();
    ma = model_reset(); mb = model_reset(); mc = model_reset();
    @(negedge clk);
    rst = 1'b1;

    // 32 enabled cycles, then a 32-advance burst, both tracked by the model.
    for (int i = 0; i < 32; i++) drive(1, 0, 0, '0, '0);
    drive(0, 0, 1, 16'd32, '0);
    idle(33);

    // Randomized traffic.
    for (int i = 0; i < 1500; i++) begin
      int r;
      logic [63:0] sd;
      r = $urandom_range(0, 99);
      sd = {$urandom, $urandom};
      if ($urandom_range(0, 3) == 0) sd = '0;
      if (r < 4)       drive($urandom_range(0, 1), 1, $urandom_range(0, 1), CW'($urandom_range(0, 12)), sd);
      else if (r < 10) drive($urandom_range(0, 1), 0, 1, CW'($urandom_range(0, 12)), sd);
      else if (r < 70) drive(1, 0, 0, CW'($urandom_range(0, 12)), sd);
      else             drive(0, 0, 0, '0, sd);
    end
    idle(2);
    after_edge();
    check_val("queues_drained", 64'(exp_a.size() + exp_b.size() + exp_c.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/lfsr_gen.md
# lfsr_gen

Parametrised Fibonacci LFSR pseudo-random source, the next generation of the fixed 32-bit enable-only LFSR. Supports selectable width, multiple steps per clock, runtime seed loading with zero-seed protection, and a counted burst mode with busy/done handshake. It sits beside the hardware priority-queue test logic as its stimulus and random-key generator.

## Interface
- W, 32: register width; legal values 8, 16, 24, 32, 64 (any other value is an elaboration error).
- SEED, 1 (W bits): reset and fallback value; must be nonzero (elaboration error if zero).
- STEPS, 1: LFSR shifts per advance, 1..W.
- CW, 16: burst count width.
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- enb  in  1  free-run enable; advance once per cycle while high.
- load  in  1  load seed_in on next edge.
- seed_in  in  W  runtime seed.
- start  in  1  single-cycle request to begin a burst.
- cnt  in  CW  burst length in advances, sampled with start.
- q  out  W  current LFSR state.
- busy  out  1  burst in progress.
- done  out  1  one-cycle pulse at burst completion.
- err  out  1  one-cycle pulse when a zero seed was rejected.

## Operation
- Single step: fb = XOR of tap bits; q_next = {q[W-2:0], fb}. Taps (1-indexed bit positions; bit n = q[n-1]): W=8: 8,6,5,4; W=16: 16,15,13,4; W=24: 24,23,22,17; W=32: 32,22,2,1; W=64: 64,63,61,60. These give maximal period 2^W-1.
- Advance = STEPS chained single steps, computed combinationally within one cycle.
- The all-zero state is never reachable: load with seed_in==0 loads SEED instead and pulses err.
- Priority per edge: load > burst/start > enb.
- load: q <= seed_in (or SEED if zero); no advance that cycle. If busy, the burst aborts: busy <= 0, no done.
- start while idle, cnt==N>0: busy <= 1; remaining <= N. Each busy cycle advances q once and decrements remaining; on the edge where remaining goes 1->0, busy <= 0 and done <= 1.
- start while idle with cnt==0: no advance; busy stays 0; done pulses on the next edge.
- start while busy: ignored.
- enb: advance when high and not busy and not loading; while busy, enb has no additional effect (exactly one advance per cycle maximum).
- State machine: IDLE (busy=0) -> RUN on start with cnt>0; RUN -> IDLE on the last count or on load. done and err are registered pulses cleared on the following edge.

## Timing
- Reset (rst low, asynchronous): q=SEED, busy=0, done=0, err=0, remaining=0, state IDLE. Deassertion is synchronous to clk by the system.
- Latency: inputs are sampled on rising edge k, and results are visible after edge k.
- Burst of N: busy is high for exactly N cycles, starting after the start edge. done is high for the one cycle after busy falls, and q then holds the final value (start value advanced N*STEPS shifts).
- Reset mid-burst: immediate return to IDLE; no done.
- Remaining-count arithmetic is unsigned CW-bit. cnt = 2^CW-1 is legal. No wrap occurs.

## Test plan
- W=8, SEED=8'h01, STEPS=1: release reset, hold enb high for 4 cycles -> q = 02, 04, 08, 11; after 255 total advances, q returns to 01.
- W=8, STEPS=4, SEED=8'h01: one cycle with enb high -> q=8'h11; with enb low, q holds for 10 cycles.
- W=8, STEPS=1, q=01, start with cnt=4, enb low -> busy high for 4 cycles; done pulses for 1 cycle with q=8'h11; a start with cnt=0 gives done next cycle and q unchanged.
- load with seed_in=0 -> q=SEED and err pulses for 1 cycle; load with 8'hA5 -> q=A5, err stays 0.
- Load during a burst of cnt=10 at cycle 3 -> busy falls, done never asserts, q=seed_in. Reset asserted mid-burst -> q=SEED, busy=0 asynchronously.
- W=32 default, SEED=1: 32 enabled cycles -> q matches the reference model every cycle; the burst result equals the enb result for the same count.
